// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param: write/read requests, read data and occupancy flags.
// The master modport drives requests; the slave modport is the FIFO itself.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_enb;
  logic [WIDTH-1:0] wr_data;
  logic             rd_enb;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             half;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    count;

  modport master (
    output flush, wr_enb, wr_data, rd_enb,
    input  rd_data, rd_valid, full, empty, half, almost_full, almost_empty,
           overflow, underflow, count
  );

  modport slave (
    input  flush, wr_enb, wr_data, rd_enb,
    output rd_data, rd_valid, full, empty, half, almost_full, almost_empty,
           overflow, underflow, count
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of arbitrary DEPTH with thresholds, occupancy count, flush and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  sync_fifo_param_if.slave      bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          underflow_reg;
`ifndef FIFO_FWFT_EN
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;
`endif

  logic is_full;
  logic is_empty;
  logic rd_accepted;
  logic wr_accepted;

  // Explicit wrap so non-power-of-2 depths never index past the last entry
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign is_full     = (count_reg == DEPTH_C);
  assign is_empty    = (count_reg == '0);
  assign rd_accepted = bus.rd_enb && !is_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a write
  assign wr_accepted = bus.wr_enb && (!is_full || rd_accepted);

  always_ff @(posedge clk) begin
    if (!rstn && !bus.flush && wr_accepted) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accepted) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (rd_accepted) rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({wr_accepted, rd_accepted})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      overflow_reg  <= bus.wr_enb && !wr_accepted;
      underflow_reg <= bus.rd_enb && !rd_accepted;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown combinationally; zero while empty so reset/flush read back as 0
  assign bus.rd_data  = is_empty ? '0 : mem[rd_ptr_reg];
  assign bus.rd_valid = !is_empty;
`else
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accepted;
      if (rd_accepted) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
`endif

  assign bus.count        = count_reg;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.half         = (count_reg >= HALF_C);
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: DEPTH=16 instance for main tests, DEPTH=5 for wrap.
// Stimulus pushes expected read words; a negedge monitor pops and compares.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] store_a[$];
  logic [7:0] exp_a[$];
  logic [7:0] store_b[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) bus_a ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(5))  bus_b ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a)
  );
  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b)
  );

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic idle_all();
    bus_a.flush = 1'b0; bus_a.wr_enb = 1'b0; bus_a.wr_data = '0; bus_a.rd_enb = 1'b0;
    bus_b.flush = 1'b0; bus_b.wr_enb = 1'b0; bus_b.wr_data = '0; bus_b.rd_enb = 1'b0;
  endtask

  // Drive one cycle; expected read word is queued now, before the edge that pops it
  task automatic step(input int sel, input bit fl, input bit w, input logic [7:0] d, input bit r);
    bit ra;
    bit wa;
    if (sel == 0) begin
      bus_a.flush = fl; bus_a.wr_enb = w; bus_a.wr_data = d; bus_a.rd_enb = r;
      if (fl) store_a.delete();
      else begin
        ra = r && (store_a.size() > 0);
        wa = w && ((store_a.size() < 16) || ra);
        if (ra) exp_a.push_back(store_a.pop_front());
        if (wa) store_a.push_back(d);
      end
    end else begin
      bus_b.flush = fl; bus_b.wr_enb = w; bus_b.wr_data = d; bus_b.rd_enb = r;
      if (fl) store_b.delete();
      else begin
        ra = r && (store_b.size() > 0);
        wa = w && ((store_b.size() < 5) || ra);
        if (ra) exp_b.push_back(store_b.pop_front());
        if (wa) store_b.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    idle_all();
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
`ifdef FIFO_FWFT_EN
      if (bus_a.rd_valid && bus_a.rd_enb) begin
`else
      if (bus_a.rd_valid) begin
`endif
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data_a unexpected: got 0x%0h expected no word", bus_a.rd_data);
        end else chk("rd_data_a", int'(bus_a.rd_data), int'(exp_a.pop_front()));
      end
`ifdef FIFO_FWFT_EN
      if (bus_b.rd_valid && bus_b.rd_enb) begin
`else
      if (bus_b.rd_valid) begin
`endif
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data_b unexpected: got 0x%0h expected no word", bus_b.rd_data);
        end else chk("rd_data_b", int'(bus_b.rd_data), int'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    chk("reset count", int'(bus_a.count), 0);
    chk("reset empty", int'(bus_a.empty), 1);
    chk("reset almost_empty", int'(bus_a.almost_empty), 1);
    chk("reset full", int'(bus_a.full), 0);
    chk("reset half", int'(bus_a.half), 0);
    chk("reset almost_full", int'(bus_a.almost_full), 0);
    chk("reset rd_valid", int'(bus_a.rd_valid), 0);
    chk("reset rd_data", int'(bus_a.rd_data), 0);
    chk("reset overflow", int'(bus_a.overflow), 0);
    chk("reset underflow", int'(bus_a.underflow), 0);
    rstn = 1'b0;
    @(posedge clk); #1;

    // Fill with 0x01..0x10, checking thresholds at every occupancy
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 8'(i), 0);
      chk($sformatf("fill count %0d", i), int'(bus_a.count), i);
      chk($sformatf("fill full %0d", i), int'(bus_a.full), (i == 16) ? 1 : 0);
      chk($sformatf("fill half %0d", i), int'(bus_a.half), (i >= 8) ? 1 : 0);
      chk($sformatf("fill almost_full %0d", i), int'(bus_a.almost_full), (i >= 14) ? 1 : 0);
      chk($sformatf("fill almost_empty %0d", i), int'(bus_a.almost_empty), (i <= 2) ? 1 : 0);
      if (i == 1) begin
`ifdef FIFO_FWFT_EN
        chk("fwft first rd_valid", int'(bus_a.rd_valid), 1);
        chk("fwft first rd_data", int'(bus_a.rd_data), 1);
`else
        chk("std no rd_valid before read", int'(bus_a.rd_valid), 0);
`endif
      end
    end

    // Write into a full FIFO is dropped
    step(0, 0, 1, 8'hAA, 0);
    chk("overflow pulse", int'(bus_a.overflow), 1);
    chk("overflow count", int'(bus_a.count), 16);
    step(0, 0, 0, 8'h00, 0);
    chk("overflow cleared", int'(bus_a.overflow), 0);

    // Simultaneous write/read while full for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 8'(8'h20 + i), 1);
      chk("both full count", int'(bus_a.count), 16);
      chk("both full overflow", int'(bus_a.overflow), 0);
    end

    // Drain
    for (int i = 15; i >= 0; i--) begin
      step(0, 0, 0, 8'h00, 1);
      chk("drain count", int'(bus_a.count), i);
    end
    chk("drained empty", int'(bus_a.empty), 1);
    step(0, 0, 0, 8'h00, 0);

    // Read from empty is dropped
    step(0, 0, 0, 8'h00, 1);
    chk("underflow pulse", int'(bus_a.underflow), 1);
    chk("underflow rd_valid", int'(bus_a.rd_valid), 0);
    step(0, 0, 0, 8'h00, 0);
    chk("underflow cleared", int'(bus_a.underflow), 0);
    step(0, 0, 1, 8'h55, 1);
    chk("empty wr+rd count", int'(bus_a.count), 1);
    chk("empty wr+rd underflow", int'(bus_a.underflow), 1);
    step(0, 0, 0, 8'h00, 1);
    chk("after pop count", int'(bus_a.count), 0);
    step(0, 0, 0, 8'h00, 0);

    // Flush at count 9 overrides a concurrent write
    for (int i = 0; i < 9; i++) step(0, 0, 1, 8'(8'h60 + i), 0);
    chk("pre-flush count", int'(bus_a.count), 9);
    step(0, 1, 1, 8'h99, 0);
    chk("flush count", int'(bus_a.count), 0);
    chk("flush empty", int'(bus_a.empty), 1);
    chk("flush overflow", int'(bus_a.overflow), 0);
    chk("flush rd_valid", int'(bus_a.rd_valid), 0);
    step(0, 0, 1, 8'h77, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Async reset mid write burst
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h70 + i), 0);
    bus_a.wr_enb = 1'b1; bus_a.wr_data = 8'h73;
    #2 rstn = 1'b1;
    #1;
    chk("async reset count", int'(bus_a.count), 0);
    chk("async reset empty", int'(bus_a.empty), 1);
    chk("async reset rd_valid", int'(bus_a.rd_valid), 0);
    chk("async reset rd_data", int'(bus_a.rd_data), 0);
    store_a.delete();
    @(posedge clk); #1;
    chk("reset held no write", int'(bus_a.count), 0);
    idle_all();
    rstn = 1'b0;
    @(posedge clk); #1;

    // DEPTH=5: alternating write/read pairs exercise pointer wrap
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, 8'(8'h80 + i), 0);
      chk("d5 count after write", int'(bus_b.count), 1);
      step(1, 0, 0, 8'h00, 1);
      chk("d5 count after read", int'(bus_b.count), 0);
    end
    step(1, 0, 0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;

    chk("scoreboard a drained", exp_a.size(), 0);
    chk("scoreboard b drained", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
